// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Defines the FSM state encoding, the MMIO address map and the byte-lane merge helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned LANES           = 4;
  localparam logic [31:0] MMIO_CYCLE_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_OUT_ADDR   = 32'hFFFF_FFF4;

  // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0]      old_word,
                                              input logic [31:0]      new_word,
                                              input logic [LANES-1:0] lane_we);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
// Written in the plain single-port style so synthesis maps it onto block RAM.
module dmem_bytelane_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Enabled access: write the selected lanes and capture the old word on the read port.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store stage with a valid/ready request
// handshake and a programmable number of wait states before the response strobe.
// Optional MMIO block (cycle counter and mmio_out register) is built with DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] daddr,
  input  logic [3:0]  dwe,
  input  logic [31:0] dwdata,
  output logic        rsp_valid,
  output logic [31:0] drdata,
  output logic        rsp_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, fire;

  logic [31:0] addr_p0, wdata_p0;
  logic [3:0]  we_p0;
  logic [31:0] cur_addr, cur_wdata, idx;
  logic [3:0]  cur_we;
  logic        in_range, is_cyc, is_mout, is_err, ram_en;

  logic        err_p1, ram_rd_p1;
  logic [31:0] mmio_rd_p1, ram_rdata, mmio_rd_val;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // The access happens on the edge entering RESP; with no wait states that is the accept edge itself.
  assign fire = !reset && (((state == IDLE) && req_valid && (WAIT_INIT == 4'd0)) ||
                           ((state == WAIT) && (cnt == 4'd1)));

  // In IDLE the live inputs are the request; afterwards only the captured copy counts.
  assign cur_addr  = (state == IDLE) ? daddr  : addr_p0;
  assign cur_we    = (state == IDLE) ? dwe    : we_p0;
  assign cur_wdata = (state == IDLE) ? dwdata : wdata_p0;

  assign idx      = (cur_addr - BASE_ADDR) >> 2;
  assign in_range = (cur_addr >= BASE_ADDR) && (idx < 32'(DEPTH_WORDS));

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;
  assign is_cyc      = ({cur_addr[31:2], 2'b00} == MMIO_CYCLE_ADDR);
  assign is_mout     = ({cur_addr[31:2], 2'b00} == MMIO_OUT_ADDR);
  assign mmio_rd_val = is_cyc ? cyc_cnt : (is_mout ? mmio_out : 32'h0);

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (reset) cyc_cnt <= 32'h0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end

  // MMIO output register, byte-lane writable.
  always_ff @(posedge clk) begin
    if (reset)                 mmio_out <= 32'h0;
    else if (fire && is_mout)  mmio_out <= merge_lanes(mmio_out, cur_wdata, cur_we);
  end
`else
  assign is_cyc      = 1'b0;
  assign is_mout     = 1'b0;
  assign mmio_rd_val = 32'h0;
`endif

  // MMIO decode wins over the array so a RAM window reaching the top of memory cannot shadow it.
  assign is_err = !(in_range || is_cyc || is_mout);
  assign ram_en = fire && in_range && !is_cyc && !is_mout;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_INIT == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter, loaded at accept and counted down through WAIT.
  always_ff @(posedge clk) begin
    if (reset)               cnt <= 4'd0;
    else if (accept)         cnt <= WAIT_INIT;
    else if (state == WAIT)  cnt <= cnt - 4'd1;
  end

  // ---- p0: request captured at accept ----
  // Request capture; inputs are ignored once the request is taken.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= daddr;
      we_p0    <= dwe;
      wdata_p0 <= dwdata;
    end
  end

  dmem_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (cur_we),
    .addr (idx[AW-1:0]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  // ---- p1: response attributes registered on the edge entering RESP ----
  // Response attributes; the RAM read word is registered inside the RAM on the same edge.
  always_ff @(posedge clk) begin
    if (fire) begin
      err_p1     <= is_err;
      ram_rd_p1  <= ram_en && (cur_we == 4'b0000);
      mmio_rd_p1 <= (cur_we == 4'b0000) ? mmio_rd_val : 32'h0;
    end
  end

  assign drdata  = rsp_valid ? (ram_rd_p1 ? ram_rdata : mmio_rd_p1) : 32'h0;
  assign rsp_err = rsp_valid && err_p1;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: reset state, directed vector table, handshake,
// reset-abort sequences on a 3-wait-state instance, and randomized traffic against a model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W1    = 1;
  localparam int unsigned W3    = 3;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk;
  logic        reset, reset3, req_valid, req_valid3;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dwe;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] drdata;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] drdata3;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out, mmio_out3;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .daddr(daddr), .dwe(dwe), .dwdata(dwdata), .rsp_valid(rsp_valid),
    .drdata(drdata), .rsp_err(rsp_err)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W3), .BASE_ADDR(BASE)) dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .daddr(daddr), .dwe(dwe), .dwdata(dwdata), .rsp_valid(rsp_valid3),
    .drdata(drdata3), .rsp_err(rsp_err3)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Which instance the transaction task talks to.
  bit          sel = 1'b0;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_data;
  assign m_ready = sel ? req_ready3 : req_ready;
  assign m_valid = sel ? rsp_valid3 : rsp_valid;
  assign m_err   = sel ? rsp_err3   : rsp_err;
  assign m_data  = sel ? drdata3    : drdata;

  int total = 0;
  int bad   = 0;
  int unsigned acc_cyc;

  // Reference model state.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] mmio_m = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model of one request on the W1 instance: returns the response and updates storage.
  function automatic void model(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                                output logic [31:0] ed, output logic ee);
    logic [31:0] off;
    ed = 32'h0;
    ee = 1'b0;
`ifdef DMEM_MMIO_EN
    if ({a[31:2], 2'b00} == 32'hFFFF_FFF4) begin
      if (we == 4'b0000) ed = mmio_m;
      for (int b = 0; b < 4; b++) if (we[b]) mmio_m[8*b +: 8] = wd[8*b +: 8];
      return;
    end
    if ({a[31:2], 2'b00} == 32'hFFFF_FFF0) return;
`endif
    off = a - BASE;
    if (a < BASE || (off / 4) >= DEPTH) begin
      ee = 1'b1;
      return;
    end
    if (we == 4'b0000) ed = mem_m[off / 4];
    else for (int b = 0; b < 4; b++) if (we[b]) mem_m[off / 4][8*b +: 8] = wd[8*b +: 8];
  endfunction

  // One complete request/response on the selected instance; lat counts edges from accept to strobe.
  task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        output logic [31:0] rd, output logic re, output int lat);
    int n;
    @(negedge clk);
    if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
    daddr = a; dwe = we; dwdata = wd;
    n = 0;
    while (!m_ready && n < 20) begin @(negedge clk); n++; end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_valid3 = 1'b0;
    daddr = $urandom; dwe = 4'($urandom); dwdata = $urandom;
    lat = 1;
    while (!m_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = m_data;
    re = m_err;
    if (!m_valid) lat = -1;
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    logic [31:0] rd;
    logic        re;
    int          lat;
    do_req(a, we, wd, rd, re, lat);
    chk({name, "_data"}, rd, ed);
    chk({name, "_err"}, 32'(re), 32'(ee));
    chk({name, "_lat"}, 32'(lat), 32'((sel ? W3 : W1) + 1));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[$];
    logic [31:0] ed, rd, c1, c2;
    logic        ee, re;
    int          lat, n, seen;
    int unsigned a1, a2;

    vt.push_back('{32'h10,  4'b1111, 32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back('{32'h10,  4'b0000, 32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back('{32'h10,  4'b0010, 32'h0000AA00, 32'h0,        1'b0});
    vt.push_back('{32'h10,  4'b0000, 32'h0,        32'hDEADAAEF, 1'b0});
    vt.push_back('{32'h20,  4'b1100, 32'h12340000, 32'h0,        1'b0});
    vt.push_back('{32'h20,  4'b0000, 32'h0,        32'h12340000, 1'b0});
    vt.push_back('{32'h100, 4'b0000, 32'h0,        32'h0,        1'b1});
    vt.push_back('{32'h100, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b1});
    vt.push_back('{32'h13,  4'b0000, 32'h0,        32'hDEADAAEF, 1'b0});
    vt.push_back('{32'h30,  4'b1001, 32'hA1B2C3D4, 32'h0,        1'b0});
    vt.push_back('{32'h30,  4'b0000, 32'h0,        32'hA10000D4, 1'b0});
    vt.push_back('{32'hFC,  4'b1111, 32'h0BADCAFE, 32'h0,        1'b0});
    vt.push_back('{32'hFC,  4'b0000, 32'h0,        32'h0BADCAFE, 1'b0});
    vt.push_back('{32'h0,   4'b0000, 32'h0,        32'h0,        1'b0});
`ifdef DMEM_MMIO_EN
    vt.push_back('{32'hFFFFFFF4, 4'b0001, 32'h000000FF, 32'h0,        1'b0});
    vt.push_back('{32'hFFFFFFF4, 4'b0000, 32'h0,        32'h000000FF, 1'b0});
`else
    vt.push_back('{32'hFFFFFFF0, 4'b0000, 32'h0,        32'h0,        1'b1});
    vt.push_back('{32'hFFFFFFF4, 4'b1111, 32'h12345678, 32'h0,        1'b1});
`endif

    reset = 1'b1; reset3 = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
    daddr = 32'h0; dwe = 4'h0; dwdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset3 = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_MMIO_EN
    chk("rst_mmio_out", mmio_out, 32'h0);
`endif

    // Zero-initialise the array through the normal write path.
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_req(32'(i * 4), 4'b1111, 32'h0, rd, re, lat);
      model(32'(i * 4), 4'b1111, 32'h0, ed, ee);
    end

    foreach (vt[i]) begin
      model(vt[i].a, vt[i].we, vt[i].wd, ed, ee);
      run($sformatf("vec%0d", i), vt[i].a, vt[i].we, vt[i].wd, vt[i].ed, vt[i].ee);
    end
`ifdef DMEM_MMIO_EN
    chk("mmio_out_val", mmio_out, 32'h000000FF);
    run("cyc_wr_ignored", 32'hFFFFFFF0, 4'b1111, 32'h12345678, 32'h0, 1'b0);
    do_req(32'hFFFFFFF0, 4'b0000, 32'h0, c1, re, lat);
    a1 = acc_cyc;
    repeat ($urandom_range(0, 7)) @(negedge clk);
    do_req(32'hFFFFFFF0, 4'b0000, 32'h0, c2, re, lat);
    a2 = acc_cyc;
    chk("cyc_delta", c2 - c1, a2 - a1);
    chk("cyc_err", 32'(re), 32'd0);
`endif

    // req_valid held high: one accept per W1+2 cycles, ready low through WAIT and RESP.
    @(negedge clk);
    req_valid = 1'b1; daddr = 32'h100; dwe = 4'b0000;
    for (int k = 0; k < 2 * int'(W1 + 2); k++) begin
      chk($sformatf("hs_ready%0d", k), 32'(req_ready), 32'((k % (W1 + 2)) == 0));
      chk($sformatf("hs_valid%0d", k), 32'(rsp_valid), 32'((k % (W1 + 2)) == W1 + 1));
      if (rsp_valid) chk($sformatf("hs_err%0d", k), 32'(rsp_err), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;

    // Randomized traffic against the model.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a, wd;
      logic [3:0]  we;
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      else                          a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095) * 4);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      wd = $urandom;
      model(a, we, wd, ed, ee);
      run($sformatf("rnd%0d", t), a, we, wd, ed, ee);
    end

    // Three-wait-state instance: reset in the first WAIT cycle aborts the write.
    sel = 1'b1;
    run("w3_init", 32'h40, 4'b1111, 32'h11112222, 32'h0, 1'b0);
    @(negedge clk);
    req_valid3 = 1'b1; daddr = 32'h40; dwe = 4'b1111; dwdata = 32'h55555555;
    @(negedge clk);
    req_valid3 = 1'b0;
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    chk("w3_abort_ready", 32'(req_ready3), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid3) seen++;
      @(negedge clk);
    end
    chk("w3_abort_no_rsp", 32'(seen), 32'd0);
    run("w3_after_abort", 32'h40, 4'b0000, 32'h0, 32'h11112222, 1'b0);

    // Reset in RESP: the write was already committed.
    @(negedge clk);
    req_valid3 = 1'b1; daddr = 32'h44; dwe = 4'b1111; dwdata = 32'h77777777;
    @(negedge clk);
    req_valid3 = 1'b0;
    n = 0;
    while (!rsp_valid3 && n < 20) begin @(negedge clk); n++; end
    chk("w3_resp_seen", 32'(rsp_valid3), 32'd1);
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    chk("w3_resp_rst_valid", 32'(rsp_valid3), 32'd0);
    chk("w3_resp_rst_ready", 32'(req_ready3), 32'd1);
    run("w3_committed", 32'h44, 4'b0000, 32'h0, 32'h77777777, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
